keypad_pin_collector: RTL and testbench
=======================================

Name: keypad_pin_collector

Overview:
- Upstream entry stage for the phone security checker.
- Accepts one keypad key per handshake and assembles four BCD digits into a 16-bit PIN, first digit in the MSB nibble.
- On ENTER, presents the PIN for exactly one clock, with zeros on all other cycles; this is the pulse-then-zero form the checker's pin_input expects.
- Also handles clear, inactivity timeout and malformed-entry signalling.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted key before a partial entry is discarded; legal range 2..65535.
- AUTO_SUBMIT, 0: 1 = submit automatically on the 4th digit without waiting for ENTER.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  key_code is valid this cycle.
- key_code  input  4  0x0-0x9 digit; 0xA CLEAR; 0xB ENTER; 0xC BACKSPACE (optional feature only); all other codes are ignored.
- key_ready  output  1  block can accept a key; a key is accepted when key_valid && key_ready.
- pin_out  output  16  assembled PIN; nonzero only while pin_valid=1; connects to the checker's pin_input.
- pin_valid  output  1  one-cycle submit strobe.
- digit_count  output  3  digits currently buffered, 0..4.
- entry_error  output  1  one-cycle pulse on malformed entry.
- timeout  output  1  one-cycle pulse when a partial entry is discarded.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - State IDLE; buffer, digit_count and idle counter = 0.
  - pin_out=0, pin_valid=0, entry_error=0, timeout=0, key_ready=1.
  - Reset asserted mid-entry or during SUBMIT discards the entry with no strobe.
- States:
  - IDLE: count=0.
  - ENTRY: count 1..3.
  - FULL: count=4.
  - SUBMIT: one cycle only.
- Accepted digit d:
  - In IDLE or ENTRY: buffer <= {buffer[11:0], d}; count+1.
  - When count reaches 4: go to FULL, or to SUBMIT if AUTO_SUBMIT=1.
  - In FULL: digit ignored, buffer unchanged, entry_error pulses.
- ENTER:
  - In FULL: go to SUBMIT.
  - In IDLE or ENTRY: entry_error pulses, buffer and count cleared, go to IDLE.
- CLEAR: in any non-SUBMIT state, buffer and count cleared, go to IDLE; no error.
- SUBMIT cycle:
  - Registered outputs: pin_valid=1, pin_out=buffer, key_ready=0.
  - Next cycle: pin_out=0, pin_valid=0, buffer and count cleared, go to IDLE.
  - Latency: pin_valid is asserted on the cycle after the ENTER is accepted, or after the 4th digit when AUTO_SUBMIT=1.
- Idle counter:
  - Cleared on every accepted key and whenever state is IDLE or SUBMIT.
  - Increments each cycle in ENTRY or FULL.
  - At TIMEOUT_CYCLES-1: timeout pulses, buffer and count cleared, go to IDLE.
  - An accepted key in the same cycle as expiry wins: the key is processed and there is no timeout.
- Unrecognised key codes are accepted (handshake completes) but have no effect and do not clear the idle counter.
- All outputs are registered. entry_error and timeout are never asserted together with pin_valid.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined:
  - Key 0xC in ENTRY or FULL: buffer <= {4'h0, buffer[15:4]}; count-1; go to IDLE if count becomes 0, ENTRY otherwise. Clears the idle counter.
  - Key 0xC in IDLE: entry_error pulses.
- Not defined: 0xC is treated as an unrecognised code (no effect).

Test Plan:
- Reset, then keys 8,6,4,2,ENTER one per cycle -> one cycle after ENTER: pin_valid=1, pin_out=16'h8642; next cycle pin_out=16'h0000, digit_count=0.
- Keys 8,4,ENTER -> entry_error single pulse, no pin_valid, digit_count=0.
- Keys 1,2,3,4,5 then ENTER -> 5 ignored with entry_error pulse; pin_out=16'h1234.
- TIMEOUT_CYCLES=8; key 3 then no keys -> timeout pulses, digit_count returns 0; a key 7 arriving exactly on the expiry cycle -> no timeout, digit_count=2.
- AUTO_SUBMIT=1; keys 3,8,4,9 -> pin_valid on the cycle after 9 with pin_out=16'h3849; key_ready=0 during that cycle; a key offered then is not accepted.
- KEYPAD_BACKSPACE_EN defined: keys 8,6,5,BACKSPACE,4,2,ENTER -> pin_out=16'h8642. Reset asserted mid-entry after 8,6 -> all outputs 0, digit_count=0, no strobe.

Source files
------------

// File: rtl/keypad_pin_collector.sv
// ============================================================================
// Module      : keypad_pin_collector
// Description : Collects four keypad BCD digits into a 16-bit PIN and presents
//               it for one clock on ENTER (or automatically on the 4th digit).
//               Optional backspace key 0xC enabled by macro KEYPAD_BACKSPACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_pin_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned AUTO_SUBMIT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] pin_out,
    output logic        pin_valid,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_FULL   = 2'd2,
        ST_SUBMIT = 2'd3
    } state_t;

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  c_key_clear    = 4'hA;
    localparam logic [3:0]  c_key_enter    = 4'hB;
    localparam logic        c_auto_submit  = (AUTO_SUBMIT != 0);

    state_t      r_state_q,       w_state_d;
    logic [15:0] r_buf_q,         w_buf_d;
    logic [2:0]  r_count_q,       w_count_d;
    logic [15:0] r_idle_q,        w_idle_d;
    logic [15:0] r_pin_out_q,     w_pin_out_d;
    logic        r_pin_valid_q,   w_pin_valid_d;
    logic        r_entry_error_q, w_entry_error_d;
    logic        r_timeout_q,     w_timeout_d;
    logic        r_key_ready_q,   w_key_ready_d;

    logic w_accept;
    logic w_key_digit;
    logic w_key_clear;
    logic w_key_enter;
    logic w_key_bksp;
    logic w_key_recog;
    logic w_expire;

    assign w_accept    = key_valid & r_key_ready_q;
    assign w_key_digit = w_accept & (key_code <= 4'd9);
    assign w_key_clear = w_accept & (key_code == c_key_clear);
    assign w_key_enter = w_accept & (key_code == c_key_enter);
`ifdef KEYPAD_BACKSPACE_EN
    assign w_key_bksp  = w_accept & (key_code == 4'hC);
`else
    assign w_key_bksp  = 1'b0;
`endif
    // Only recognised keys count as activity for the inactivity timer.
    assign w_key_recog = w_key_digit | w_key_clear | w_key_enter | w_key_bksp;
    assign w_expire    = (r_idle_q == c_timeout_last);

    always_comb begin
        w_state_d       = r_state_q;
        w_buf_d         = r_buf_q;
        w_count_d       = r_count_q;
        w_pin_out_d     = 16'h0000;
        w_pin_valid_d   = 1'b0;
        w_entry_error_d = 1'b0;
        w_timeout_d     = 1'b0;

        case (r_state_q)
            ST_IDLE, ST_ENTRY: begin
                if (w_key_digit) begin
                    w_buf_d   = {r_buf_q[11:0], key_code};
                    w_count_d = r_count_q + 3'd1;
                    if (r_count_q == 3'd3) begin
                        if (c_auto_submit) begin
                            w_state_d     = ST_SUBMIT;
                            w_pin_valid_d = 1'b1;
                            w_pin_out_d   = {r_buf_q[11:0], key_code};
                        end else begin
                            w_state_d = ST_FULL;
                        end
                    end else begin
                        w_state_d = ST_ENTRY;
                    end
                end else if (w_key_enter) begin
                    w_entry_error_d = 1'b1;
                    w_buf_d         = 16'h0000;
                    w_count_d       = 3'd0;
                    w_state_d       = ST_IDLE;
                end else if (w_key_clear) begin
                    w_buf_d   = 16'h0000;
                    w_count_d = 3'd0;
                    w_state_d = ST_IDLE;
                end else if (w_key_bksp) begin
                    if (r_state_q == ST_IDLE) begin
                        w_entry_error_d = 1'b1;
                    end else begin
                        w_buf_d   = {4'h0, r_buf_q[15:4]};
                        w_count_d = r_count_q - 3'd1;
                        w_state_d = (r_count_q == 3'd1) ? ST_IDLE : ST_ENTRY;
                    end
                end else if ((r_state_q == ST_ENTRY) && w_expire) begin
                    w_timeout_d = 1'b1;
                    w_buf_d     = 16'h0000;
                    w_count_d   = 3'd0;
                    w_state_d   = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (w_key_digit) begin
                    w_entry_error_d = 1'b1;
                end else if (w_key_enter) begin
                    w_state_d     = ST_SUBMIT;
                    w_pin_valid_d = 1'b1;
                    w_pin_out_d   = r_buf_q;
                end else if (w_key_clear) begin
                    w_buf_d   = 16'h0000;
                    w_count_d = 3'd0;
                    w_state_d = ST_IDLE;
                end else if (w_key_bksp) begin
                    w_buf_d   = {4'h0, r_buf_q[15:4]};
                    w_count_d = 3'd3;
                    w_state_d = ST_ENTRY;
                end else if (w_expire) begin
                    w_timeout_d = 1'b1;
                    w_buf_d     = 16'h0000;
                    w_count_d   = 3'd0;
                    w_state_d   = ST_IDLE;
                end
            end
            default: begin
                w_buf_d   = 16'h0000;
                w_count_d = 3'd0;
                w_state_d = ST_IDLE;
            end
        endcase

        w_key_ready_d = (w_state_d != ST_SUBMIT);

        if ((r_state_q == ST_IDLE) || (r_state_q == ST_SUBMIT) ||
            w_key_recog || (w_state_d == ST_IDLE)) begin
            w_idle_d = 16'h0000;
        end else begin
            w_idle_d = r_idle_q + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= ST_IDLE;
            r_buf_q         <= 16'h0000;
            r_count_q       <= 3'd0;
            r_idle_q        <= 16'h0000;
            r_pin_out_q     <= 16'h0000;
            r_pin_valid_q   <= 1'b0;
            r_entry_error_q <= 1'b0;
            r_timeout_q     <= 1'b0;
            r_key_ready_q   <= 1'b1;
        end else begin
            r_state_q       <= w_state_d;
            r_buf_q         <= w_buf_d;
            r_count_q       <= w_count_d;
            r_idle_q        <= w_idle_d;
            r_pin_out_q     <= w_pin_out_d;
            r_pin_valid_q   <= w_pin_valid_d;
            r_entry_error_q <= w_entry_error_d;
            r_timeout_q     <= w_timeout_d;
            r_key_ready_q   <= w_key_ready_d;
        end
    end

    assign key_ready   = r_key_ready_q;
    assign pin_out     = r_pin_out_q;
    assign pin_valid   = r_pin_valid_q;
    assign digit_count = r_count_q;
    assign entry_error = r_entry_error_q;
    assign timeout     = r_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_pin_collector.sv
// ============================================================================
// Module      : tb_keypad_pin_collector
// Description : Directed self-checking bench; one manual-ENTER instance with a
//               short timeout and one auto-submit instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_pin_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_ready;
    logic [15:0] pin_out;
    logic        pin_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    logic        a_key_valid = 1'b0;
    logic [3:0]  a_key_code = 4'h0;
    logic        a_key_ready;
    logic [15:0] a_pin_out;
    logic        a_pin_valid;
    logic [2:0]  a_digit_count;
    logic        a_entry_error;
    logic        a_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keypad_pin_collector #(.TIMEOUT_CYCLES(8), .AUTO_SUBMIT(0)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .pin_out(pin_out), .pin_valid(pin_valid),
        .digit_count(digit_count), .entry_error(entry_error), .timeout(timeout)
    );

    keypad_pin_collector #(.TIMEOUT_CYCLES(1000), .AUTO_SUBMIT(1)) dut_auto (
        .clk(clk), .reset(reset), .key_valid(a_key_valid), .key_code(a_key_code),
        .key_ready(a_key_ready), .pin_out(a_pin_out), .pin_valid(a_pin_valid),
        .digit_count(a_digit_count), .entry_error(a_entry_error), .timeout(a_timeout)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic atick(input logic v, input logic [3:0] c);
        a_key_valid = v;
        a_key_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick(0, 4'h0);
        tick(0, 4'h0);
        reset = 1'b0;
        chk("rst_pin_out", pin_out, 16'h0000);
        chk("rst_pin_valid", 16'(pin_valid), 16'h0);
        chk("rst_count", 16'(digit_count), 16'h0);
        chk("rst_err", 16'(entry_error), 16'h0);
        chk("rst_timeout", 16'(timeout), 16'h0);
        chk("rst_ready", 16'(key_ready), 16'h1);

        // 8,6,4,2,ENTER
        tick(1, 4'h8);
        chk("t1_count1", 16'(digit_count), 16'h1);
        tick(1, 4'h6);
        tick(1, 4'h4);
        tick(1, 4'h2);
        chk("t1_count4", 16'(digit_count), 16'h4);
        chk("t1_no_early_valid", 16'(pin_valid), 16'h0);
        tick(1, 4'hB);
        chk("t1_valid", 16'(pin_valid), 16'h1);
        chk("t1_pin", pin_out, 16'h8642);
        chk("t1_ready_low", 16'(key_ready), 16'h0);
        tick(0, 4'h0);
        chk("t1_valid_drop", 16'(pin_valid), 16'h0);
        chk("t1_pin_zero", pin_out, 16'h0000);
        chk("t1_count0", 16'(digit_count), 16'h0);
        chk("t1_ready_back", 16'(key_ready), 16'h1);

        // 8,4,ENTER -> malformed entry
        tick(1, 4'h8);
        tick(1, 4'h4);
        chk("t2_count2", 16'(digit_count), 16'h2);
        tick(1, 4'hB);
        chk("t2_err", 16'(entry_error), 16'h1);
        chk("t2_no_valid", 16'(pin_valid), 16'h0);
        chk("t2_count0", 16'(digit_count), 16'h0);
        tick(0, 4'h0);
        chk("t2_err_pulse", 16'(entry_error), 16'h0);

        // 1,2,3,4,5,ENTER -> 5 rejected
        tick(1, 4'h1);
        tick(1, 4'h2);
        tick(1, 4'h3);
        tick(1, 4'h4);
        chk("t3_err_none", 16'(entry_error), 16'h0);
        tick(1, 4'h5);
        chk("t3_err_5th", 16'(entry_error), 16'h1);
        chk("t3_count4", 16'(digit_count), 16'h4);
        tick(1, 4'hB);
        chk("t3_valid", 16'(pin_valid), 16'h1);
        chk("t3_pin", pin_out, 16'h1234);
        chk("t3_err_clr", 16'(entry_error), 16'h0);
        tick(0, 4'h0);

        // Timeout after 8 idle cycles
        tick(1, 4'h3);
        repeat (7) tick(0, 4'h0);
        chk("t4_not_yet", 16'(timeout), 16'h0);
        chk("t4_count1", 16'(digit_count), 16'h1);
        tick(0, 4'h0);
        chk("t4_timeout", 16'(timeout), 16'h1);
        chk("t4_count0", 16'(digit_count), 16'h0);
        tick(0, 4'h0);
        chk("t4_timeout_pulse", 16'(timeout), 16'h0);

        // Key on the expiry cycle wins
        tick(1, 4'h3);
        repeat (7) tick(0, 4'h0);
        tick(1, 4'h7);
        chk("t5_no_timeout", 16'(timeout), 16'h0);
        chk("t5_count2", 16'(digit_count), 16'h2);
        tick(0, 4'h0);
        chk("t5_no_timeout2", 16'(timeout), 16'h0);
        tick(1, 4'hA);
        chk("t5_clear_count", 16'(digit_count), 16'h0);
        chk("t5_clear_noerr", 16'(entry_error), 16'h0);

        // Unrecognised keys do not refresh the inactivity timer
        tick(1, 4'h9);
        repeat (7) tick(1, 4'hD);
        chk("t6_count1", 16'(digit_count), 16'h1);
        tick(1, 4'hD);
        chk("t6_timeout", 16'(timeout), 16'h1);
        chk("t6_count0", 16'(digit_count), 16'h0);

        // Key 0xC
        tick(1, 4'h8);
        tick(1, 4'h6);
        tick(1, 4'h5);
        tick(1, 4'hC);
`ifdef KEYPAD_BACKSPACE_EN
        chk("t7_bksp_count", 16'(digit_count), 16'h2);
        tick(1, 4'h4);
        tick(1, 4'h2);
        tick(1, 4'hB);
        chk("t7_bksp_pin", pin_out, 16'h8642);
        chk("t7_bksp_valid", 16'(pin_valid), 16'h1);
        tick(0, 4'h0);
        tick(1, 4'hC);
        chk("t7_bksp_idle_err", 16'(entry_error), 16'h1);
`else
        chk("t7_c_ignored", 16'(digit_count), 16'h3);
        chk("t7_c_noerr", 16'(entry_error), 16'h0);
        tick(1, 4'hA);
`endif
        tick(0, 4'h0);

        // Reset mid-entry discards without strobe
        tick(1, 4'h8);
        tick(1, 4'h6);
        reset = 1'b1;
        tick(0, 4'h0);
        chk("t8_count0", 16'(digit_count), 16'h0);
        chk("t8_pin0", pin_out, 16'h0000);
        chk("t8_valid0", 16'(pin_valid), 16'h0);
        reset = 1'b0;
        tick(1, 4'hB);
        chk("t8_enter_err", 16'(entry_error), 16'h1);
        chk("t8_enter_novalid", 16'(pin_valid), 16'h0);
        tick(0, 4'h0);

        // Auto-submit instance: 3,8,4,9
        atick(1, 4'h3);
        atick(1, 4'h8);
        atick(1, 4'h4);
        chk("a_count3", 16'(a_digit_count), 16'h3);
        atick(1, 4'h9);
        chk("a_valid", 16'(a_pin_valid), 16'h1);
        chk("a_pin", a_pin_out, 16'h3849);
        chk("a_ready_low", 16'(a_key_ready), 16'h0);
        chk("a_no_err", 16'(a_entry_error), 16'h0);
        atick(1, 4'h5);
        chk("a_valid_drop", 16'(a_pin_valid), 16'h0);
        chk("a_pin_zero", a_pin_out, 16'h0000);
        chk("a_count0", 16'(a_digit_count), 16'h0);
        atick(0, 4'h0);
        chk("a_key_not_taken", 16'(a_digit_count), 16'h0);
        chk("a_ready_back", 16'(a_key_ready), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
